// File: rtl/freq_pkg.sv
// Shared FSM state type, widths and result codes for the frequency-gate sequencer.
package freq_pkg;

  typedef enum logic [2:0] {IDLE, GATE, LATCH, CONVERT, PUBLISH} state_e;

  localparam int unsigned BCD_W       = 16;
  localparam int unsigned BIN_W       = 14;
  localparam int unsigned CONV_CYCLES = 14;

  localparam logic [BCD_W-1:0] OVF_BLANK_CODE = 16'hFFFF;
  localparam logic [BCD_W-1:0] OVF_SAT_CODE   = 16'h9999;

  // One double-dabble correction step: add 3 to every nibble that is 5 or more.
  function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    res = bcd;
    for (int i = 0; i < int'(BCD_W / 4); i++) begin
      if (bcd[4*i +: 4] >= 4'd5) res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    return res;
  endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble: 14-bit binary to 4-digit packed BCD, fixed 14-cycle latency.
module bin2bcd_serial
  import freq_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [BIN_W-1:0] i_bin,
  output logic [BCD_W-1:0] o_bcd,
  output logic             o_done
);

  logic [BIN_W-1:0] r_bin;
  logic [BCD_W-1:0] r_bcd;
  logic [3:0]       r_cnt;
  logic             r_active;
  logic [BCD_W-1:0] w_adj;
  logic             w_last;

  assign w_adj  = bcd_adjust(r_bcd);
  assign w_last = r_active && (r_cnt == 4'(CONV_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bin    <= '0;
      r_bcd    <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else if (i_start) begin
      r_bin    <= i_bin;
      r_bcd    <= '0;
      r_cnt    <= '0;
      r_active <= 1'b1;
    end else if (r_active) begin
      r_bcd <= {w_adj[BCD_W-2:0], r_bin[BIN_W-1]};
      r_bin <= {r_bin[BIN_W-2:0], 1'b0};
      r_cnt <= r_cnt + 4'd1;
      if (w_last) r_active <= 1'b0;
    end
  end

  // done marks the final shift cycle; o_bcd holds the result from the next cycle on.
  assign o_done = w_last;
  assign o_bcd  = r_bcd;

endmodule

// File: rtl/freq_gate_sequencer.sv
// Gated edge counter with serial BCD conversion and one-cycle publish strobe.
// Build option OVERFLOW_BLANK_EN: overflow publishes 16'hFFFF instead of 16'h9999.
module freq_gate_sequencer
  import freq_pkg::*;
#(
  parameter int unsigned GATE_TICKS = 100000000,
  parameter int unsigned TICK_W     = 27,
  parameter int unsigned EDGE_W     = 17,
  parameter int unsigned MAX_DISP   = 9999
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             run,
  output logic [BCD_W-1:0] freq_bcd,
  output logic             freq_valid,
  output logic             overflow,
  output logic             busy
);

  localparam logic [EDGE_W-1:0] EDGE_MAX = '1;

  state_e            r_state, w_state_next;
  logic              r_sync1, r_sync2, r_prev;
  logic              w_edge_pulse;
  logic [TICK_W-1:0] r_tick;
  logic [EDGE_W-1:0] r_edge;
  logic              r_ovf_pend;
  logic              w_gate_last;
  logic              w_in_gate, w_start, w_publish;
  logic              w_conv_done;
  logic [BCD_W-1:0]  w_conv_bcd;
  logic [BCD_W-1:0]  w_ovf_code;
  logic [BCD_W-1:0]  r_freq_bcd;
  logic              r_freq_valid, r_overflow;

`ifdef OVERFLOW_BLANK_EN
  assign w_ovf_code = OVF_BLANK_CODE;
`else
  assign w_ovf_code = OVF_SAT_CODE;
`endif

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= sig_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_edge_pulse = r_sync2 & ~r_prev;
  assign w_gate_last  = (r_tick == TICK_W'(GATE_TICKS - 1));

  always_ff @(posedge CLK) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (run) w_state_next = GATE;
      GATE: begin
        if (!run)             w_state_next = IDLE;
        else if (w_gate_last) w_state_next = LATCH;
      end
      LATCH:   w_state_next = CONVERT;
      CONVERT: if (w_conv_done) w_state_next = PUBLISH;
      PUBLISH: w_state_next = run ? GATE : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = (r_state != IDLE);
    w_in_gate = (r_state == GATE);
    w_start   = (r_state == LATCH);
    w_publish = (r_state == PUBLISH);
  end

  // Counters run only inside the gate and sit at zero otherwise, so every gate starts clean.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_tick     <= '0;
      r_edge     <= '0;
      r_ovf_pend <= 1'b0;
    end else begin
      if (w_in_gate) begin
        r_tick <= r_tick + TICK_W'(1);
        if (w_edge_pulse && (r_edge != EDGE_MAX)) r_edge <= r_edge + EDGE_W'(1);
      end else begin
        r_tick <= '0;
        r_edge <= '0;
      end
      if (w_start) r_ovf_pend <= (r_edge > EDGE_W'(MAX_DISP));
    end
  end

  bin2bcd_serial u_bin2bcd (
    .i_clk   (CLK),
    .i_rst   (reset),
    .i_start (w_start),
    .i_bin   (r_edge[BIN_W-1:0]),
    .o_bcd   (w_conv_bcd),
    .o_done  (w_conv_done)
  );

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_freq_bcd   <= '0;
      r_freq_valid <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_freq_valid <= w_publish;
      if (w_publish) begin
        r_overflow <= r_ovf_pend;
        r_freq_bcd <= r_ovf_pend ? w_ovf_code : w_conv_bcd;
      end
    end
  end

  assign freq_bcd   = r_freq_bcd;
  assign freq_valid = r_freq_valid;
  assign overflow   = r_overflow;

endmodule
